// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter tracking the bits still to send in a frame; zero marks the LSB.
module piso_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_MAX;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: accepts a word over valid/ready and sends it
// MSB first, one bit per enabled clock, flagging the LSB with ser_last.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             cnt_zero;
    logic             accept;
    logic             cnt_dec;

    assign busy       = (state == SHIFT);
    assign ser_valid  = busy;
    assign ser_out    = shreg[WIDTH-1];
    assign ser_last   = busy && cnt_zero;
    assign load_ready = (state == IDLE) || (ser_last && shift_en);

    // set outranks a load, so a word offered alongside set stays with upstream.
    assign accept  = load_valid && load_ready && !set;
    assign cnt_dec = busy && shift_en && !cnt_zero;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .reset(reset),
        .load (set || accept),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
        end else if (set) begin
            state <= SHIFT;
            shreg <= '1;
        end else if (accept) begin
            state <= SHIFT;
            shreg <= load_data;
        end else if (busy && shift_en) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (cnt_zero) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in, parallel-out register `reg4`. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB first, with a last-bit marker. The MSB-first order means a left-shifting receiver on the far end rebuilds the word unchanged. It sits between word-level logic and a single-wire serial link.

## Interface
- WIDTH, 4, number of bits per word; must be 2 or more.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- set  input  1  synchronous, active-high; starts an all-ones frame.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to transmit.
- shift_en  input  1  advance the shifter this cycle; low holds all state.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_last  output  1  ser_out is the final (LSB) bit of the frame.
- busy  output  1  frame in progress (state SHIFT).

## Operation
- **States:**
  - IDLE: shreg holds its last value, ser_valid=0, load_ready=1.
  - SHIFT: ser_valid=1.
- **Registers:** shreg[WIDTH-1:0], cnt (width $clog2(WIDTH)), state.
- **Combinational outputs:**
  - ser_out = shreg[WIDTH-1].
  - ser_last = (state==SHIFT) && (cnt==0).
  - load_ready = (state==IDLE) || (ser_last && shift_en).
  - busy = (state==SHIFT).
- **Accept:** load_valid && load_ready at a rising edge. Then shreg <= load_data, cnt <= WIDTH-1, state <= SHIFT.
- **SHIFT with shift_en=1, cnt>0:** shreg <= {shreg[WIDTH-2:0],1'b0}, cnt <= cnt-1.
- **SHIFT with shift_en=1, cnt==0:**
  - With an accept in the same cycle, the next frame loads; there is no bubble.
  - Without an accept, state <= IDLE and shreg shifts as normal (ends all zero).
- **SHIFT with shift_en=0:** shreg, cnt and state hold, and outputs are stable. load_ready stays low unless state is IDLE. A held last bit keeps ser_last=1.
- **IDLE:** shift_en has no effect. Only an accept or set changes state.
- **set:** priority reset > set > accept > shift.
  - set forces shreg <= all ones, cnt <= WIDTH-1, state <= SHIFT.
  - It applies in any state and does not depend on shift_en.
  - It aborts a frame in progress; remaining bits are dropped.
  - A load presented in the same cycle is not accepted, even though load_ready may read 1. The upstream holds its data.
- **reset (async):** shreg=0, cnt=0, state=IDLE. Resulting outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0, load_ready=1. Assertion mid-frame aborts it immediately, without waiting for a clock edge.

## Timing
- Word accepted at edge k: the MSB appears on ser_out after edge k.
- Bit i (MSB = bit WIDTH-1) is presented during the (WIDTH-1-i)-th enabled cycle after k.
- With shift_en held high: frame occupies cycles k+1..k+WIDTH, and ser_last=1 in cycle k+WIDTH.
- Back-to-back throughput with shift_en high: one bit per clock, 100% link utilisation.
- load_ready depends combinationally on shift_en. Upstream must not make load_valid depend on load_ready.
- Data is sampled only on an accept. After the accept, load_data may change freely.

## Structure
- **Package piso_pkg:** state enum (IDLE, SHIFT) and default WIDTH constant.
- **Sub-module piso_bit_counter:**
  - Down-counter with load, decrement enable, and zero flag.
  - Parameter WIDTH.
  - Instantiated once.
- **Top level:** FSM, shreg, and output logic.

## Test plan
1. **Reset value:** assert reset mid-cycle. Check immediately ser_valid=0, busy=0, ser_out=0, load_ready=1.
2. **Single frame:** WIDTH=4, load 4'b1011, shift_en=1.
   - ser_out = 1,0,1,1 on the 4 following cycles, ser_valid=1 throughout.
   - ser_last only on the 4th cycle; then idle.
3. **Back-to-back:** load 4'b1100, then present 4'b0011 during its last bit. Stream is 1,1,0,0,0,0,1,1 with no gap, and ser_last on cycles 4 and 8.
4. **Stall:** load 4'b1001 and drop shift_en for 3 cycles after the 2nd bit. ser_out holds 0 and cnt holds; after shift_en returns, 0,1 follow and ser_last appears on the final 1.
5. **set abort:** mid-frame of 4'b0000, pulse set for one cycle with load_valid=1.
   - Output becomes 1,1,1,1 framed, and the load is not accepted.
   - That data is accepted after this frame.
6. **Async reset mid-frame:** assert reset between edges during bit 2. Outputs return to reset values before the next edge, and a subsequent load of 4'b0110 transmits correctly.
